grf_sb: RTL and testbench
=========================

# grf_sb

Parametrised general register file with an integrated write scoreboard, the next-generation GRF for the multi-issue pipeline. It provides READ_NUM combinational read ports with internal write forwarding and WRITE_NUM write ports, each with its own enable. A per-register pending-write counter lets the issue stage reserve a destination and read a per-port ready bit, replacing external hazard-tracking logic. It sits between decode/issue (reads, allocations) and writeback (writes).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W; register 0 is hardwired zero
- READ_NUM, 2, number of read ports
- WRITE_NUM, 1, number of write (writeback) ports
- ALLOC_NUM, 1, number of allocation (issue) ports
- PEND_W, 2, pending-counter width; max outstanding writes per register = 2**PEND_W-1

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- radds  in  ADDR_W x READ_NUM  read addresses
- rdatas  out  DATA_W x READ_NUM  read data, forwarded
- rrdy  out  1 x READ_NUM  read port ready (no outstanding write beyond this cycle)
- wes  in  1 x WRITE_NUM  per-port write enable
- wadds  in  ADDR_W x WRITE_NUM  write addresses
- wdatas  in  DATA_W x WRITE_NUM  write data
- alloc_vld  in  1 x ALLOC_NUM  allocation request
- alloc_adds  in  ADDR_W x ALLOC_NUM  destination to reserve
- alloc_rdy  out  1 x ALLOC_NUM  allocation accepted this cycle
- err  out  1  sticky: write retired to a nonzero register whose counter was 0

## Operation
- Storage: 2**ADDR_W registers of DATA_W; cnt[r] pending counter of PEND_W bits per register.
- Register 0: reads always 0, rrdy always 1, writes and allocations to it are ignored; allocation to 0 is accepted (alloc_rdy=1) but counts nothing.
- Read data: rdatas[i] = regs[radds[i]], overridden by wdatas[j] of any port with wes[j]=1, wadds[j]=radds[i]≠0; if several ports match, highest j wins.
- Write: on clock, each port with wes[j]=1 and wadds[j]≠0 updates regs; same-address conflict → highest j wins.
- Write retire: each enabled write to r≠0 decrements cnt[r] by one; k ports to same r decrement by k; counter saturates at 0 (no underflow). A write retiring with cnt[r] below the number of matching ports sets err.
- Allocation: port k accepted iff alloc_vld[k], and cnt[r] + (number of accepted lower-index ports with same r) + 1 ≤ 2**PEND_W-1; same-cycle retirements are not credited (conservative). alloc_rdy[k] is combinational and 0 when alloc_vld[k]=0. Each accepted request increments cnt[r].
- Net counter update per cycle: cnt[r] ← cnt[r] + accepted_allocs(r) − min(cnt[r], retires(r)).
- Ready: rrdy[i] = 1 iff radds[i]=0, or cnt[radds[i]] ≤ retires(radds[i]) this cycle (all outstanding writes retire now, data is forwarded). Same-cycle allocations do not affect rrdy until next cycle.
- err cleared only by reset.

## Timing
- Reads, rrdy, alloc_rdy: purely combinational, zero latency.
- Writes visible via forwarding in the same cycle, from storage the next cycle.
- Counter and err updates take effect on the rising edge after the request.
- Reset asserted (any time, including mid-cycle with writes/allocs active): all regs=0, all cnt=0, err=0 immediately; rdatas=0 (absent forwarding writes), rrdy all 1, alloc_rdy equals alloc_vld while counters are 0. Writes and allocations during reset are discarded; forwarding stays active combinationally.
- Reset deassertion: first update on the next rising edge.

## Test plan
- Reset then read all 32 registers → rdatas=0, rrdy=1, err=0; write 0xDEADBEEF to r0 → r0 still reads 0.
- Alloc r5 (cnt 0→1), next cycle read r5 → rrdy=0; write 0x1234 to r5 with same-cycle read → rdatas=0x1234, rrdy=1; next cycle cnt=0, storage 0x1234.
- Alloc r7 three times (PEND_W=2) → cnt=3; fourth alloc → alloc_rdy=0, cnt stays 3; write r7 and alloc r7 same cycle → alloc_rdy=0, cnt=2.
- WRITE_NUM=2: both ports write r3 (0xA, 0xB) with cnt[r3]=2 → read forwards 0xB, storage 0xB, cnt=0, err=0; repeat with cnt[r3]=1 → cnt=0, err=1.
- Write r9 with cnt=0 → regs updated, err=1 sticky across further clean traffic until reset.
- Assert reset asynchronously mid-cycle with cnt[r4]=2, r4=0x55 → err, counters, storage clear immediately without clock edge; rrdy for r4=1.

Source files
------------

// File: rtl/grf_sb.sv
// General register file with combinational forwarded reads and a per-register
// pending-write scoreboard that reports read readiness and accepts destination reservations.
module grf_sb #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int READ_NUM  = 2,
  parameter int WRITE_NUM = 1,
  parameter int ALLOC_NUM = 1,
  parameter int PEND_W    = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [READ_NUM-1:0][ADDR_W-1:0]     radds,
  output logic [READ_NUM-1:0][DATA_W-1:0]     rdatas,
  output logic [READ_NUM-1:0]                 rrdy,
  input  logic [WRITE_NUM-1:0]                wes,
  input  logic [WRITE_NUM-1:0][ADDR_W-1:0]    wadds,
  input  logic [WRITE_NUM-1:0][DATA_W-1:0]    wdatas,
  input  logic [ALLOC_NUM-1:0]                alloc_vld,
  input  logic [ALLOC_NUM-1:0][ADDR_W-1:0]    alloc_adds,
  output logic [ALLOC_NUM-1:0]                alloc_rdy,
  output logic                                err
);

  localparam int DEPTH = 1 << ADDR_W;
  // Wide enough for a counter value plus every same-cycle alloc or retire.
  localparam int NUM_W = PEND_W + $clog2(WRITE_NUM + ALLOC_NUM + 1) + 1;
  typedef logic [NUM_W-1:0] num_t;
  localparam num_t CNT_MAX = num_t'((1 << PEND_W) - 1);

  logic [DATA_W-1:0] regs    [DEPTH];
  logic [PEND_W-1:0] cnt     [DEPTH];
  logic [PEND_W-1:0] cnt_nxt [DEPTH];
  logic              err_hit;
  logic [ALLOC_NUM-1:0][PEND_W-1:0] alloc_cur;

  // Number of enabled write ports targeting address a (caller excludes r0).
  function automatic num_t count_writes(
    input logic [ADDR_W-1:0]                 a,
    input logic [WRITE_NUM-1:0]              we,
    input logic [WRITE_NUM-1:0][ADDR_W-1:0]  wa
  );
    num_t n;
    n = '0;
    for (int j = 0; j < WRITE_NUM; j++) begin
      if (we[j] && (wa[j] == a)) n = n + num_t'(1);
    end
    return n;
  endfunction

  // Lower-index ports claim counter headroom first; same-cycle retirements
  // are deliberately not credited.
  function automatic logic [ALLOC_NUM-1:0] grant_allocs(
    input logic [ALLOC_NUM-1:0]              vld,
    input logic [ALLOC_NUM-1:0][ADDR_W-1:0]  adds,
    input logic [ALLOC_NUM-1:0][PEND_W-1:0]  cur
  );
    logic [ALLOC_NUM-1:0] g;
    num_t                 same;
    g = '0;
    for (int k = 0; k < ALLOC_NUM; k++) begin
      same = '0;
      for (int m = 0; m < k; m++) begin
        if (g[m] && (adds[m] == adds[k])) same = same + num_t'(1);
      end
      g[k] = vld[k] && ((adds[k] == '0) ||
                        ((num_t'(cur[k]) + same + num_t'(1)) <= CNT_MAX));
    end
    return g;
  endfunction

  // Read ports: storage value overridden by the highest matching write port.
  always_comb begin
    for (int i = 0; i < READ_NUM; i++) begin
      rdatas[i] = regs[radds[i]];
      for (int j = 0; j < WRITE_NUM; j++) begin
        if (wes[j] && (wadds[j] == radds[i])) rdatas[i] = wdatas[j];
      end
      if (radds[i] == '0) rdatas[i] = '0;
      rrdy[i] = (radds[i] == '0) ||
                (num_t'(cnt[radds[i]]) <= count_writes(radds[i], wes, wadds));
    end
  end

  // Handshake: alloc_vld[k] requests a reservation; alloc_rdy[k] is its
  // combinational acceptance, and the reservation takes effect only when
  // both are high at a rising edge. alloc_rdy never asserts without alloc_vld.
  always_comb begin
    for (int k = 0; k < ALLOC_NUM; k++) alloc_cur[k] = cnt[alloc_adds[k]];
  end

  assign alloc_rdy = grant_allocs(alloc_vld, alloc_adds, alloc_cur);

  // Counter next state: cnt + accepted allocs - min(cnt, retires).
  always_comb begin
    num_t ret;
    num_t add;
    num_t cur;
    num_t dec;
    err_hit = 1'b0;
    ret     = '0;
    add     = '0;
    cur     = '0;
    dec     = '0;
    cnt_nxt[0] = '0;
    for (int r = 1; r < DEPTH; r++) begin
      ret = count_writes(ADDR_W'(r), wes, wadds);
      add = '0;
      for (int k = 0; k < ALLOC_NUM; k++) begin
        if (alloc_rdy[k] && (alloc_adds[k] == ADDR_W'(r))) add = add + num_t'(1);
      end
      cur = num_t'(cnt[r]);
      if (ret > cur) begin
        err_hit = 1'b1;
        dec     = cur;
      end else begin
        dec     = ret;
      end
      cnt_nxt[r] = PEND_W'(cur + add - dec);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      err <= 1'b0;
    end else begin
      for (int r = 0; r < DEPTH; r++) cnt[r] <= cnt_nxt[r];
      if (err_hit) err <= 1'b1;
      // Ascending order so the highest port wins an address conflict.
      for (int j = 0; j < WRITE_NUM; j++) begin
        if (wes[j] && (wadds[j] != '0)) regs[wadds[j]] <= wdatas[j];
      end
    end
  end

endmodule

// File: tb/tb_grf_sb.sv
// Bench for grf_sb with two write and two alloc ports: a reference model predicts
// every combinational output each cycle through an expected-value queue.
module tb_grf_sb;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int READ_NUM  = 2;
  localparam int WRITE_NUM = 2;
  localparam int ALLOC_NUM = 2;
  localparam int PEND_W    = 2;
  localparam int DEPTH     = 32;
  localparam int CNT_MAX   = 3;

  logic                               clk;
  logic                               reset;
  logic [READ_NUM-1:0][ADDR_W-1:0]    radds;
  logic [READ_NUM-1:0][DATA_W-1:0]    rdatas;
  logic [READ_NUM-1:0]                rrdy;
  logic [WRITE_NUM-1:0]               wes;
  logic [WRITE_NUM-1:0][ADDR_W-1:0]   wadds;
  logic [WRITE_NUM-1:0][DATA_W-1:0]   wdatas;
  logic [ALLOC_NUM-1:0]               alloc_vld;
  logic [ALLOC_NUM-1:0][ADDR_W-1:0]   alloc_adds;
  logic [ALLOC_NUM-1:0]               alloc_rdy;
  logic                               err;

  grf_sb #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_NUM(READ_NUM),
    .WRITE_NUM(WRITE_NUM), .ALLOC_NUM(ALLOC_NUM), .PEND_W(PEND_W)
  ) dut (
    .clk(clk), .reset(reset), .radds(radds), .rdatas(rdatas), .rrdy(rrdy),
    .wes(wes), .wadds(wadds), .wdatas(wdatas), .alloc_vld(alloc_vld),
    .alloc_adds(alloc_adds), .alloc_rdy(alloc_rdy), .err(err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  logic [31:0] m_regs [DEPTH];
  int          m_cnt  [DEPTH];
  bit          m_err;
  logic [ALLOC_NUM-1:0] m_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nret(input int a);
    int n = 0;
    for (int j = 0; j < WRITE_NUM; j++)
      if (wes[j] && int'(wadds[j]) == a) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < DEPTH; r++) begin
      m_regs[r] = '0;
      m_cnt[r]  = 0;
    end
    m_err = 1'b0;
  endtask

  // scoreboard: predict outputs into exp_q, then pop and compare
  task automatic check_comb();
    int          add [DEPTH];
    logic [31:0] d;
    int          a;
    for (int r = 0; r < DEPTH; r++) add[r] = 0;
    for (int i = 0; i < READ_NUM; i++) begin
      a = int'(radds[i]);
      d = m_regs[a];
      for (int j = 0; j < WRITE_NUM; j++)
        if (wes[j] && int'(wadds[j]) == a) d = wdatas[j];
      if (a == 0) d = '0;
      exp_q.push_back(d);
      exp_q.push_back((a == 0 || m_cnt[a] <= nret(a)) ? 32'd1 : 32'd0);
    end
    m_acc = '0;
    for (int k = 0; k < ALLOC_NUM; k++) begin
      a = int'(alloc_adds[k]);
      if (alloc_vld[k] && (a == 0 || m_cnt[a] + add[a] + 1 <= CNT_MAX)) begin
        m_acc[k] = 1'b1;
        if (a != 0) add[a]++;
      end
    end
    exp_q.push_back(32'(m_acc));
    exp_q.push_back(32'(m_err));
    chk("rdata0",    rdatas[0],       exp_q.pop_front());
    chk("rrdy0",     32'(rrdy[0]),    exp_q.pop_front());
    chk("rdata1",    rdatas[1],       exp_q.pop_front());
    chk("rrdy1",     32'(rrdy[1]),    exp_q.pop_front());
    chk("alloc_rdy", 32'(alloc_rdy),  exp_q.pop_front());
    chk("err",       32'(err),        exp_q.pop_front());
  endtask

  task automatic update_model();
    int ret, add, dec;
    if (reset) return;
    for (int r = 1; r < DEPTH; r++) begin
      ret = nret(r);
      add = 0;
      for (int k = 0; k < ALLOC_NUM; k++)
        if (m_acc[k] && int'(alloc_adds[k]) == r) add++;
      if (ret > m_cnt[r]) m_err = 1'b1;
      dec = (ret < m_cnt[r]) ? ret : m_cnt[r];
      m_cnt[r] = m_cnt[r] + add - dec;
    end
    for (int j = 0; j < WRITE_NUM; j++)
      if (wes[j] && wadds[j] != '0) m_regs[wadds[j]] = wdatas[j];
  endtask

  // driver tasks
  task automatic idle();
    radds = '0; wes = '0; wadds = '0; wdatas = '0;
    alloc_vld = '0; alloc_adds = '0;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_comb();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic rd(input int a0, input int a1);
    idle();
    radds[0] = ADDR_W'(a0);
    radds[1] = ADDR_W'(a1);
  endtask

  task automatic wr(input int port, input int a, input logic [31:0] d);
    wes[port]    = 1'b1;
    wadds[port]  = ADDR_W'(a);
    wdatas[port] = d;
  endtask

  task automatic al(input int port, input int a);
    alloc_vld[port]  = 1'b1;
    alloc_adds[port] = ADDR_W'(a);
  endtask

  task automatic sync_reset();
    idle();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_comb();
    reset = 1'b0;

    // all registers read zero and ready after reset
    for (int a = 0; a < DEPTH; a++) begin
      rd(a, DEPTH - 1 - a);
      cycle();
    end
    // r0 is hardwired zero
    rd(0, 0); wr(0, 0, 32'hDEADBEEF); cycle();
    rd(0, 1); cycle();

    // r5 reserve, stall, forward, retire
    rd(5, 5); al(0, 5); cycle();
    rd(5, 0); cycle();
    rd(5, 5); wr(0, 5, 32'h1234); cycle();
    rd(5, 5); cycle();

    // r7 counter saturation at CNT_MAX
    for (int n = 0; n < 4; n++) begin
      rd(7, 0); al(0, 7); cycle();
    end
    rd(7, 7); wr(0, 7, 32'h70); al(0, 7); cycle();
    rd(7, 0); cycle();
    rd(7, 0); al(0, 7); al(1, 7); cycle();
    rd(7, 7); wr(0, 7, 32'h71); wr(1, 7, 32'h72); cycle();
    rd(7, 0); wr(1, 7, 32'h73); cycle();
    rd(7, 7); cycle();

    // two writers to r3, clean then underflowing
    rd(3, 0); al(0, 3); al(1, 3); cycle();
    rd(3, 3); wr(0, 3, 32'hA); wr(1, 3, 32'hB); cycle();
    rd(3, 3); cycle();
    rd(3, 0); al(0, 3); cycle();
    rd(3, 3); wr(0, 3, 32'hA); wr(1, 3, 32'hB); cycle();
    rd(3, 3); cycle();

    // err sticky after write to unreserved r9
    sync_reset();
    rd(9, 0); cycle();
    rd(9, 9); wr(0, 9, 32'h99); cycle();
    for (int n = 0; n < 3; n++) begin
      rd(9, 2); al(0, 2); cycle();
      rd(2, 9); wr(0, 2, 32'h20 + 32'(n)); cycle();
    end

    // asynchronous reset mid-cycle with r4 outstanding
    rd(4, 0); wr(0, 4, 32'h55); cycle();
    rd(4, 4); al(0, 4); al(1, 4); cycle();
    rd(4, 4); cycle();
    rd(4, 6); wr(0, 6, 32'h77); al(0, 4); al(1, 4);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_comb();
    @(posedge clk);
    #1;
    check_comb();
    idle();
    reset = 1'b0;
    rd(4, 6); cycle();
    rd(4, 6); al(0, 4); cycle();

    // random traffic on a small address set
    sync_reset();
    for (int n = 0; n < 400; n++) begin
      idle();
      for (int i = 0; i < READ_NUM; i++) radds[i] = ADDR_W'($urandom_range(0, 7));
      for (int j = 0; j < WRITE_NUM; j++) begin
        wes[j]    = ($urandom_range(0, 3) == 0);
        wadds[j]  = ADDR_W'($urandom_range(0, 7));
        wdatas[j] = $urandom;
      end
      for (int k = 0; k < ALLOC_NUM; k++) begin
        alloc_vld[k]  = ($urandom_range(0, 2) == 0);
        alloc_adds[k] = ADDR_W'($urandom_range(0, 7));
      end
      cycle();
      if (n == 200) sync_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
